// File: rtl/ysyx_23060286_ifu.sv
// rtl/ysyx_23060286_ifu.sv - instruction fetch unit: PC, one-deep imem request/response, latched instruction
module ysyx_23060286_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  op,
  output logic [2:0]  f3,
  output logic        f7,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] retired
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  // Next fetch address; only consumed in the accept cycle, so redirect is ignored otherwise.
  assign next_pc = redirect ? redirect_target : pc + 32'd4;

  // Handshake outputs decode from the state register only; rst masks them while asserted.
  always_comb begin
    imem_req_valid = (state == S_REQ)  && !rst;
    imem_rsp_ready = (state == S_WAIT) && !rst;
    inst_valid     = (state == S_HOLD) && !rst;
    fault          = (state == S_FAULT);
  end

  assign imem_req_addr = pc;
  assign op            = inst[6:0];
  assign f3            = inst[14:12];
  assign f7            = inst[30];

  // Fetch sequencing: request, wait for the word, hold it until accepted, or park on a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst     <= 32'd0;
      inst_pc  <= 32'd0;
      retired  <= 32'd0;
      fault_pc <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fault_pc <= pc;
              state    <= S_FAULT;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            retired <= retired + 32'd1;
            // A misaligned successor faults before it is ever requested; pc keeps the last good value.
            if (next_pc[1:0] != 2'b00) begin
              fault_pc <= next_pc;
              state    <= S_FAULT;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
          end
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060286_ifu.sv
// tb/tb_ysyx_23060286_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_23060286_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_retired = 0;
  logic [63:0] sb[$];

  ysyx_23060286_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .op(op), .f3(f3), .f7(f7),
    .redirect(redirect), .redirect_target(redirect_target),
    .fault(fault), .fault_pc(fault_pc), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    end
    rst = 1'b0;
    sb.delete();
    exp_retired = 0;
    @(negedge clk);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h8000_0000);
    chk("post_rst_retired", retired, 32'd0);
    chk("post_rst_fault", 32'(fault), 32'd0);
    chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_op", 32'(op), 32'd0);
  endtask

  // Memory side: wait for a request, optionally stall the handshake and the response.
  task automatic serve(input logic [31:0] exp_addr, input int req_dly, input int rsp_dly,
                       input logic [31:0] data, input logic err, output int seen_cyc);
    int n = 0;
    logic [31:0] a;
    while (!imem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    seen_cyc = cyc;
    a = imem_req_addr;
    chk("req_addr", a, exp_addr);
    for (int i = 0; i < req_dly; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, a);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    chk("wait_req_drop", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      chk("late_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      chk("late_inst_valid", 32'(inst_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    imem_rsp_err = err;
    if (!err) sb.push_back({data, a});
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
  endtask

  // Downstream side: hold off for a while (with a decoy redirect), then accept.
  task automatic accept(input int hold, input logic red, input logic [31:0] tgt);
    int n = 0;
    logic [31:0] w;
    logic [63:0] e;
    while (!inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("inst_valid", 32'(inst_valid), 32'd1);
    w = inst;
    for (int i = 0; i < hold; i++) begin
      redirect = 1'b1;
      redirect_target = 32'h8000_0200;
      @(negedge clk);
      chk("hold_inst_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, w);
      chk("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("inst", inst, e[63:32]);
      chk("inst_pc", inst_pc, e[31:0]);
      chk("op", 32'(op), 32'(e[38:32]));
      chk("f3", 32'(f3), 32'(e[46:44]));
      chk("f7", 32'(f7), 32'(e[62]));
    end
    inst_ready = 1'b1;
    redirect = red;
    redirect_target = tgt;
    @(negedge clk);
    inst_ready = 1'b0;
    redirect = 1'b0;
    exp_retired++;
    chk("retired", retired, 32'(exp_retired));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2;
    do_reset(3);

    // Zero-wait stream at 3-cycle spacing
    serve(32'h8000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);
    serve(32'h8000_0004, 0, 0, 32'h00a0_0093, 1'b0, c1);
    chk("spacing1", 32'(c1 - c0), 32'd3);
    chk("op_word2", 32'(op), 32'h13);
    chk("f3_word2", 32'(f3), 32'd0);
    chk("f7_word2", 32'(f7), 32'd0);
    accept(0, 1'b0, 32'd0);
    serve(32'h8000_0008, 0, 0, 32'h0010_0073, 1'b0, c2);
    chk("spacing2", 32'(c2 - c1), 32'd3);
    accept(0, 1'b0, 32'd0);
    chk("retired_stream", retired, 32'd3);

    // Backpressure on every channel; decoy redirect during hold must be ignored
    serve(32'h8000_000C, 4, 5, 32'hc0de_50b3, 1'b0, c0);
    accept(6, 1'b0, 32'd0);

    // Taken redirect, then a misaligned redirect target
    serve(32'h8000_0010, 0, 0, 32'h4000_8033, 1'b0, c0);
    accept(0, 1'b1, 32'h8000_0100);
    serve(32'h8000_0100, 0, 0, 32'h0000_006f, 1'b0, c0);
    accept(0, 1'b1, 32'h8000_0102);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h8000_0102);
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
      chk("mis_fault_sticky", 32'(fault), 32'd1);
    end
    imem_req_ready = 1'b0;

    // Response error on the second fetch
    do_reset(2);
    serve(32'h8000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);
    serve(32'h8000_0004, 0, 0, 32'hdead_beef, 1'b1, c0);
    chk("err_fault", 32'(fault), 32'd1);
    chk("err_fault_pc", fault_pc, 32'h8000_0004);
    for (int i = 0; i < 8; i++) begin
      imem_rsp_valid = 1'b1;
      @(negedge clk);
      chk("err_no_inst", 32'(inst_valid), 32'd0);
      chk("err_no_req", 32'(imem_req_valid), 32'd0);
      chk("err_no_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    end
    imem_rsp_valid = 1'b0;

    // Reset while waiting for a response
    do_reset(1);
    serve(32'h8000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("midwait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    do_reset(1);

    // Reset while holding an instruction
    serve(32'h8000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);
    serve(32'h8000_0004, 0, 0, 32'h0010_0093, 1'b0, c0);
    chk("midhold_inst_valid", 32'(inst_valid), 32'd1);
    do_reset(1);

    // PC wrap through redirect to the top word
    serve(32'h8000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b1, 32'hFFFF_FFFC);
    serve(32'hFFFF_FFFC, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);
    serve(32'h0000_0000, 0, 0, 32'h0000_0013, 1'b0, c0);
    accept(0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
